// File: rtl/rv_initiator_pkg.sv
// ---------------------------------------------------------------------------
// rv_initiator_pkg
//   Shared types and helpers for the ready-valid register-port initiator.
//   - state_t   : initiator FSM states
//   - cmd_t     : latched command (write flag + payload). The payload field is
//                 sized for the widest supported bus. Users cast it down to
//                 their own DATA_WIDTH.
//   - cnt_width : width of the bus-wait counter for a given TIMEOUT
// ---------------------------------------------------------------------------
package rv_initiator_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      RESP    = 2'd3
   } state_t;

   // Widest DATA_WIDTH the command latch can carry.
   localparam int CMD_DATA_MAX_W = 64;

   typedef struct packed {
      logic                      write;
      logic [CMD_DATA_MAX_W-1:0] data;
   } cmd_t;

   // Counter must be able to hold TIMEOUT-1; never narrower than one bit so
   // that TIMEOUT=0 still yields a legal (constant-zero) register.
   function automatic int cnt_width(input int timeout);
      int w;
      w = $clog2(timeout + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rv_initiator_if.sv
// ---------------------------------------------------------------------------
// rv_initiator_if
//   Bundles the command, response and device register-port channels of the
//   initiator.
//   master : initiator side (drives CMD_READY, RSP_*, READ_READY, WRITE_*)
//   slave  : environment side (controller plus device)
// ---------------------------------------------------------------------------
interface rv_initiator_if #(
   parameter int DATA_WIDTH = 8
);
   // Command channel
   logic                  CMD_VALID_I;
   logic                  CMD_READY_O;
   logic                  CMD_WRITE_I;
   logic [DATA_WIDTH-1:0] CMD_DATA_I;
   // Response channel
   logic                  RSP_VALID_O;
   logic                  RSP_READY_I;
   logic [DATA_WIDTH-1:0] RSP_DATA_O;
   logic                  RSP_ERROR_O;
   // Device read channel
   logic                  READ_READY_O;
   logic                  READ_VALID_I;
   logic [DATA_WIDTH-1:0] READ_DATA_I;
   // Device write channel
   logic                  WRITE_VALID_O;
   logic                  WRITE_READY_I;
   logic [DATA_WIDTH-1:0] WRITE_DATA_O;

   modport master (
      input  CMD_VALID_I, CMD_WRITE_I, CMD_DATA_I,
      output CMD_READY_O,
      output RSP_VALID_O, RSP_DATA_O, RSP_ERROR_O,
      input  RSP_READY_I,
      output READ_READY_O,
      input  READ_VALID_I, READ_DATA_I,
      output WRITE_VALID_O, WRITE_DATA_O,
      input  WRITE_READY_I
   );

   modport slave (
      output CMD_VALID_I, CMD_WRITE_I, CMD_DATA_I,
      input  CMD_READY_O,
      input  RSP_VALID_O, RSP_DATA_O, RSP_ERROR_O,
      output RSP_READY_I,
      input  READ_READY_O,
      output READ_VALID_I, READ_DATA_I,
      input  WRITE_VALID_O, WRITE_DATA_O,
      output WRITE_READY_I
   );

endinterface

// File: rtl/rv_timeout_counter.sv
// ---------------------------------------------------------------------------
// rv_timeout_counter
//   Bus-wait counter for the initiator.
//   Ports:
//     clk     : clock, rising edge
//     rst     : synchronous active-high reset
//     clear   : restart counting from 0 (takes priority over enable)
//     enable  : count one more wait cycle
//     expired : count == TIMEOUT-1 with TIMEOUT > 0
//   The count saturates at TIMEOUT-1 and never wraps. TIMEOUT=0 pins it at 0
//   and keeps expired low forever.
// ---------------------------------------------------------------------------
module rv_timeout_counter
   import rv_initiator_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int             CNT_W = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign expired = (TIMEOUT > 0) && (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expired && (TIMEOUT > 0)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/rv_initiator.sv
// ---------------------------------------------------------------------------
// rv_initiator
//   Runs one read or write transfer against a device ready-valid register
//   port per accepted command, and returns exactly one response (read data
//   or a timeout error).
//   Parameters:
//     DATA_WIDTH : command / response / bus data width
//     TIMEOUT    : bus-wait cycles before abort; 0 disables the timeout
//   Ports:
//     CLK_I : clock, rising edge
//     RST_I : synchronous active-high reset; drops any in-flight command
//     bus   : rv_initiator_if.master (command, response, device channels)
//   All bus-side and response outputs decode from registers only.
//   CMD_READY_O is additionally gated by RST_I.
// ---------------------------------------------------------------------------
module rv_initiator
   import rv_initiator_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic          CLK_I,
   input  logic          RST_I,
   rv_initiator_if.master bus
);

   state_t                state_q, state_d;
   cmd_t                  cmd_q, cmd_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  rsp_error_q, rsp_error_d;

   logic cnt_clear;
   logic cnt_enable;
   logic cnt_expired;
   logic bus_hs;

   rv_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (CLK_I),
      .rst     (RST_I),
      .clear   (cnt_clear),
      .enable  (cnt_enable),
      .expired (cnt_expired)
   );

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      rsp_data_d  = rsp_data_q;
      rsp_error_d = rsp_error_q;
      cnt_clear   = 1'b0;
      cnt_enable  = 1'b0;
      // Handshake of whichever device channel the latched command uses.
      bus_hs      = cmd_q.write ? bus.WRITE_READY_I : bus.READ_VALID_I;

      unique case (state_q)
         IDLE: begin
            if (bus.CMD_VALID_I) begin
               cmd_d.write = bus.CMD_WRITE_I;
               cmd_d.data  = CMD_DATA_MAX_W'(bus.CMD_DATA_I);
               cnt_clear   = 1'b1;
               state_d     = bus.CMD_WRITE_I ? WR_WAIT : RD_WAIT;
            end
         end

         RD_WAIT, WR_WAIT: begin
            // Handshake wins over timeout in the same cycle.
            if (bus_hs) begin
               rsp_data_d  = cmd_q.write ? '0 : bus.READ_DATA_I;
               rsp_error_d = 1'b0;
               state_d     = RESP;
            end else if (cnt_expired) begin
               rsp_data_d  = '0;
               rsp_error_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_enable  = 1'b1;
            end
         end

         RESP: begin
            if (bus.RSP_READY_I) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q     <= IDLE;
         cmd_q       <= '0;
         rsp_data_q  <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         rsp_data_q  <= rsp_data_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   assign bus.CMD_READY_O   = (state_q == IDLE) && !RST_I;
   assign bus.READ_READY_O  = (state_q == RD_WAIT);
   assign bus.WRITE_VALID_O = (state_q == WR_WAIT);
   assign bus.WRITE_DATA_O  = DATA_WIDTH'(cmd_q.data);
   assign bus.RSP_VALID_O   = (state_q == RESP);
   assign bus.RSP_DATA_O    = rsp_data_q;
   assign bus.RSP_ERROR_O   = rsp_error_q;

endmodule

// File: tb/tb_rv_initiator.sv
// ---------------------------------------------------------------------------
// tb_rv_initiator
//   Directed bench for rv_initiator. Three instances share one stimulus set:
//   u_main (TIMEOUT=255), u_t4 (TIMEOUT=4) and u_t0 (TIMEOUT=0).
//   Inputs change and outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_rv_initiator;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_write;
   logic [DW-1:0] cmd_data;
   logic          rsp_ready;
   logic          read_valid;
   logic [DW-1:0] read_data;
   logic          write_ready;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rv_initiator_if #(.DATA_WIDTH(DW)) if_main ();
   rv_initiator_if #(.DATA_WIDTH(DW)) if_t4 ();
   rv_initiator_if #(.DATA_WIDTH(DW)) if_t0 ();

   assign if_main.CMD_VALID_I   = cmd_valid;
   assign if_main.CMD_WRITE_I   = cmd_write;
   assign if_main.CMD_DATA_I    = cmd_data;
   assign if_main.RSP_READY_I   = rsp_ready;
   assign if_main.READ_VALID_I  = read_valid;
   assign if_main.READ_DATA_I   = read_data;
   assign if_main.WRITE_READY_I = write_ready;

   assign if_t4.CMD_VALID_I     = cmd_valid;
   assign if_t4.CMD_WRITE_I     = cmd_write;
   assign if_t4.CMD_DATA_I      = cmd_data;
   assign if_t4.RSP_READY_I     = rsp_ready;
   assign if_t4.READ_VALID_I    = read_valid;
   assign if_t4.READ_DATA_I     = read_data;
   assign if_t4.WRITE_READY_I   = write_ready;

   assign if_t0.CMD_VALID_I     = cmd_valid;
   assign if_t0.CMD_WRITE_I     = cmd_write;
   assign if_t0.CMD_DATA_I      = cmd_data;
   assign if_t0.RSP_READY_I     = rsp_ready;
   assign if_t0.READ_VALID_I    = read_valid;
   assign if_t0.READ_DATA_I     = read_data;
   assign if_t0.WRITE_READY_I   = write_ready;

   rv_initiator #(.DATA_WIDTH(DW), .TIMEOUT(255)) u_main (.CLK_I(clk), .RST_I(rst), .bus(if_main));
   rv_initiator #(.DATA_WIDTH(DW), .TIMEOUT(4))   u_t4   (.CLK_I(clk), .RST_I(rst), .bus(if_t4));
   rv_initiator #(.DATA_WIDTH(DW), .TIMEOUT(0))   u_t0   (.CLK_I(clk), .RST_I(rst), .bus(if_t0));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++; if (if_main.CMD_READY_O !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready got=%0h exp=0", if_main.CMD_READY_O); end
      n_checks++; if (if_main.RSP_VALID_O !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%0h exp=0", if_main.RSP_VALID_O); end
      n_checks++; if (if_main.READ_READY_O !== 1'b0) begin n_fail++; $display("FAIL rst_read_ready got=%0h exp=0", if_main.READ_READY_O); end
      n_checks++; if (if_main.WRITE_VALID_O !== 1'b0) begin n_fail++; $display("FAIL rst_write_valid got=%0h exp=0", if_main.WRITE_VALID_O); end
      n_checks++; if (if_main.RSP_DATA_O !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_data got=%0h exp=0", if_main.RSP_DATA_O); end
      n_checks++; if (if_main.RSP_ERROR_O !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_error got=%0h exp=0", if_main.RSP_ERROR_O); end
      n_checks++; if (if_main.WRITE_DATA_O !== 8'h00) begin n_fail++; $display("FAIL rst_write_data got=%0h exp=0", if_main.WRITE_DATA_O); end
      rst = 1'b0;
      #1;
      n_checks++; if (if_main.CMD_READY_O !== 1'b1) begin n_fail++; $display("FAIL rst_release_cmd_ready got=%0h exp=1", if_main.CMD_READY_O); end
   endtask

   task automatic test_read_immediate();
      do_reset();
      read_valid = 1'b1;
      read_data  = 8'hA5;
      cmd_valid  = 1'b1;
      cmd_write  = 1'b0;
      cmd_data   = 8'hFF;
      #1;
      n_checks++; if (if_main.CMD_READY_O !== 1'b1) begin n_fail++; $display("FAIL rd_imm_cmd_ready got=%0h exp=1", if_main.CMD_READY_O); end
      n_checks++; if (if_main.READ_READY_O !== 1'b0) begin n_fail++; $display("FAIL rd_imm_idle_read_ready got=%0h exp=0", if_main.READ_READY_O); end
      tick();
      cmd_valid = 1'b0;
      // cycle 1
      n_checks++; if (if_main.READ_READY_O !== 1'b1) begin n_fail++; $display("FAIL rd_imm_read_ready_c1 got=%0h exp=1", if_main.READ_READY_O); end
      n_checks++; if (if_main.RSP_VALID_O !== 1'b0) begin n_fail++; $display("FAIL rd_imm_rsp_valid_c1 got=%0h exp=0", if_main.RSP_VALID_O); end
      n_checks++; if (if_main.CMD_READY_O !== 1'b0) begin n_fail++; $display("FAIL rd_imm_cmd_ready_c1 got=%0h exp=0", if_main.CMD_READY_O); end
      tick();
      read_valid = 1'b0;
      // cycle 2
      n_checks++; if (if_main.RSP_VALID_O !== 1'b1) begin n_fail++; $display("FAIL rd_imm_rsp_valid_c2 got=%0h exp=1", if_main.RSP_VALID_O); end
      n_checks++; if (if_main.RSP_DATA_O !== 8'hA5) begin n_fail++; $display("FAIL rd_imm_rsp_data got=%0h exp=a5", if_main.RSP_DATA_O); end
      n_checks++; if (if_main.RSP_ERROR_O !== 1'b0) begin n_fail++; $display("FAIL rd_imm_rsp_error got=%0h exp=0", if_main.RSP_ERROR_O); end
      n_checks++; if (if_main.READ_READY_O !== 1'b0) begin n_fail++; $display("FAIL rd_imm_read_ready_c2 got=%0h exp=0", if_main.READ_READY_O); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_checks++; if (if_main.RSP_VALID_O !== 1'b0) begin n_fail++; $display("FAIL rd_imm_rsp_done got=%0h exp=0", if_main.RSP_VALID_O); end
      n_checks++; if (if_main.CMD_READY_O !== 1'b1) begin n_fail++; $display("FAIL rd_imm_back_idle got=%0h exp=1", if_main.CMD_READY_O); end
   endtask

   task automatic test_write_delayed();
      do_reset();
      write_ready = 1'b0;
      cmd_valid   = 1'b1;
      cmd_write   = 1'b1;
      cmd_data    = 8'h3C;
      tick();
      cmd_valid = 1'b0;
      cmd_data  = 8'h00;
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (if_main.WRITE_VALID_O !== 1'b1) begin n_fail++; $display("FAIL wr_dly_write_valid c%0d got=%0h exp=1", i + 1, if_main.WRITE_VALID_O); end
         n_checks++; if (if_main.WRITE_DATA_O !== 8'h3C) begin n_fail++; $display("FAIL wr_dly_write_data c%0d got=%0h exp=3c", i + 1, if_main.WRITE_DATA_O); end
         n_checks++; if (if_main.RSP_VALID_O !== 1'b0) begin n_fail++; $display("FAIL wr_dly_early_rsp c%0d got=%0h exp=0", i + 1, if_main.RSP_VALID_O); end
         if (i == 4) write_ready = 1'b1;
         tick();
      end
      write_ready = 1'b0;
      n_checks++; if (if_main.WRITE_VALID_O !== 1'b0) begin n_fail++; $display("FAIL wr_dly_write_valid_after got=%0h exp=0", if_main.WRITE_VALID_O); end
      n_checks++; if (if_main.RSP_VALID_O !== 1'b1) begin n_fail++; $display("FAIL wr_dly_rsp_valid got=%0h exp=1", if_main.RSP_VALID_O); end
      n_checks++; if (if_main.RSP_ERROR_O !== 1'b0) begin n_fail++; $display("FAIL wr_dly_rsp_error got=%0h exp=0", if_main.RSP_ERROR_O); end
      n_checks++; if (if_main.RSP_DATA_O !== 8'h00) begin n_fail++; $display("FAIL wr_dly_rsp_data got=%0h exp=0", if_main.RSP_DATA_O); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_timeout();
      // Read with no device answer: TIMEOUT=4 instance must abort.
      do_reset();
      read_valid = 1'b0;
      cmd_valid  = 1'b1;
      cmd_write  = 1'b0;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (if_t4.READ_READY_O !== 1'b1) begin n_fail++; $display("FAIL tmo_read_ready c%0d got=%0h exp=1", i + 1, if_t4.READ_READY_O); end
         n_checks++; if (if_t4.RSP_VALID_O !== 1'b0) begin n_fail++; $display("FAIL tmo_early_rsp c%0d got=%0h exp=0", i + 1, if_t4.RSP_VALID_O); end
         tick();
      end
      n_checks++; if (if_t4.READ_READY_O !== 1'b0) begin n_fail++; $display("FAIL tmo_read_ready_end got=%0h exp=0", if_t4.READ_READY_O); end
      n_checks++; if (if_t4.RSP_VALID_O !== 1'b1) begin n_fail++; $display("FAIL tmo_rsp_valid got=%0h exp=1", if_t4.RSP_VALID_O); end
      n_checks++; if (if_t4.RSP_ERROR_O !== 1'b1) begin n_fail++; $display("FAIL tmo_rsp_error got=%0h exp=1", if_t4.RSP_ERROR_O); end
      n_checks++; if (if_t4.RSP_DATA_O !== 8'h00) begin n_fail++; $display("FAIL tmo_rsp_data got=%0h exp=0", if_t4.RSP_DATA_O); end
      // The 255 instance is still waiting at this point.
      n_checks++; if (if_main.READ_READY_O !== 1'b1) begin n_fail++; $display("FAIL tmo_main_still_wait got=%0h exp=1", if_main.READ_READY_O); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Device answers in the 4th wait cycle: handshake beats the timeout.
      do_reset();
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            read_valid = 1'b1;
            read_data  = 8'h5A;
         end
         tick();
      end
      read_valid = 1'b0;
      n_checks++; if (if_t4.RSP_VALID_O !== 1'b1) begin n_fail++; $display("FAIL tmo_edge_rsp_valid got=%0h exp=1", if_t4.RSP_VALID_O); end
      n_checks++; if (if_t4.RSP_ERROR_O !== 1'b0) begin n_fail++; $display("FAIL tmo_edge_rsp_error got=%0h exp=0", if_t4.RSP_ERROR_O); end
      n_checks++; if (if_t4.RSP_DATA_O !== 8'h5A) begin n_fail++; $display("FAIL tmo_edge_rsp_data got=%0h exp=5a", if_t4.RSP_DATA_O); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      do_reset();
      read_valid = 1'b1;
      read_data  = 8'h77;
      cmd_valid  = 1'b1;
      cmd_write  = 1'b0;
      tick();
      cmd_valid = 1'b0;
      tick();
      read_valid = 1'b0;
      rsp_ready  = 1'b0;
      // Response held for 10 cycles while a new command and stray read data knock.
      for (int i = 0; i < 10; i++) begin
         cmd_valid  = 1'b1;
         cmd_write  = 1'b1;
         cmd_data   = 8'h42;
         read_valid = (i % 2 == 0);
         read_data  = 8'hEE;
         #1;
         n_checks++; if (if_main.RSP_VALID_O !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_valid c%0d got=%0h exp=1", i, if_main.RSP_VALID_O); end
         n_checks++; if (if_main.RSP_DATA_O !== 8'h77) begin n_fail++; $display("FAIL bp_rsp_data c%0d got=%0h exp=77", i, if_main.RSP_DATA_O); end
         n_checks++; if (if_main.RSP_ERROR_O !== 1'b0) begin n_fail++; $display("FAIL bp_rsp_error c%0d got=%0h exp=0", i, if_main.RSP_ERROR_O); end
         n_checks++; if (if_main.CMD_READY_O !== 1'b0) begin n_fail++; $display("FAIL bp_cmd_ready c%0d got=%0h exp=0", i, if_main.CMD_READY_O); end
         n_checks++; if (if_main.READ_READY_O !== 1'b0) begin n_fail++; $display("FAIL bp_read_ready c%0d got=%0h exp=0", i, if_main.READ_READY_O); end
         tick();
      end
      cmd_valid  = 1'b0;
      read_valid = 1'b0;
      rsp_ready  = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_checks++; if (if_main.RSP_VALID_O !== 1'b0) begin n_fail++; $display("FAIL bp_rsp_released got=%0h exp=0", if_main.RSP_VALID_O); end
      n_checks++; if (if_main.CMD_READY_O !== 1'b1) begin n_fail++; $display("FAIL bp_back_idle got=%0h exp=1", if_main.CMD_READY_O); end
      // Unsolicited read data in IDLE is never acknowledged.
      for (int i = 0; i < 3; i++) begin
         read_valid = 1'b1;
         read_data  = 8'hEE;
         #1;
         n_checks++; if (if_main.READ_READY_O !== 1'b0) begin n_fail++; $display("FAIL unsol_read_ready c%0d got=%0h exp=0", i, if_main.READ_READY_O); end
         tick();
      end
      read_valid = 1'b0;
      n_checks++; if (if_main.RSP_VALID_O !== 1'b0) begin n_fail++; $display("FAIL unsol_rsp_valid got=%0h exp=0", if_main.RSP_VALID_O); end
      n_checks++; if (if_main.CMD_READY_O !== 1'b1) begin n_fail++; $display("FAIL unsol_cmd_ready got=%0h exp=1", if_main.CMD_READY_O); end
   endtask

   task automatic test_reset_mid_write();
      do_reset();
      write_ready = 1'b0;
      cmd_valid   = 1'b1;
      cmd_write   = 1'b1;
      cmd_data    = 8'h99;
      tick();
      cmd_valid = 1'b0;
      n_checks++; if (if_main.WRITE_VALID_O !== 1'b1) begin n_fail++; $display("FAIL rstw_write_valid_c1 got=%0h exp=1", if_main.WRITE_VALID_O); end
      tick();
      tick();
      // cycle 3 of WR_WAIT
      rst         = 1'b1;
      write_ready = 1'b1;
      #1;
      n_checks++; if (if_main.CMD_READY_O !== 1'b0) begin n_fail++; $display("FAIL rstw_cmd_ready_in_rst got=%0h exp=0", if_main.CMD_READY_O); end
      tick();
      n_checks++; if (if_main.WRITE_VALID_O !== 1'b0) begin n_fail++; $display("FAIL rstw_write_valid_after got=%0h exp=0", if_main.WRITE_VALID_O); end
      n_checks++; if (if_main.RSP_VALID_O !== 1'b0) begin n_fail++; $display("FAIL rstw_rsp_valid_in_rst got=%0h exp=0", if_main.RSP_VALID_O); end
      n_checks++; if (if_main.CMD_READY_O !== 1'b0) begin n_fail++; $display("FAIL rstw_cmd_ready_gated got=%0h exp=0", if_main.CMD_READY_O); end
      n_checks++; if (if_main.WRITE_DATA_O !== 8'h00) begin n_fail++; $display("FAIL rstw_write_data_clr got=%0h exp=0", if_main.WRITE_DATA_O); end
      rst = 1'b0;
      #1;
      n_checks++; if (if_main.CMD_READY_O !== 1'b1) begin n_fail++; $display("FAIL rstw_cmd_ready_release got=%0h exp=1", if_main.CMD_READY_O); end
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (if_main.RSP_VALID_O !== 1'b0) begin n_fail++; $display("FAIL rstw_no_rsp c%0d got=%0h exp=0", i, if_main.RSP_VALID_O); end
      end
      rsp_ready   = 1'b0;
      write_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      rsp_ready   = 1'b1;
      read_valid  = 1'b1;
      read_data   = 8'h11;
      write_ready = 1'b1;
      cmd_valid   = 1'b1;
      cmd_write   = 1'b0;
      cmd_data    = 8'h00;
      #1;
      n_checks++; if (if_t0.CMD_READY_O !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ready got=%0h exp=1", if_t0.CMD_READY_O); end
      tick(); // edge 0: read accepted
      cmd_write = 1'b1;
      cmd_data  = 8'h22;
      #1;
      n_checks++; if (if_t0.CMD_READY_O !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_c1 got=%0h exp=0", if_t0.CMD_READY_O); end
      tick(); // edge 1: device handshake
      n_checks++; if (if_t0.RSP_VALID_O !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_rsp_valid got=%0h exp=1", if_t0.RSP_VALID_O); end
      n_checks++; if (if_t0.RSP_DATA_O !== 8'h11) begin n_fail++; $display("FAIL b2b_rd_rsp_data got=%0h exp=11", if_t0.RSP_DATA_O); end
      n_checks++; if (if_t0.CMD_READY_O !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_c2 got=%0h exp=0", if_t0.CMD_READY_O); end
      tick(); // edge 2: response consumed
      n_checks++; if (if_t0.CMD_READY_O !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_c3 got=%0h exp=1", if_t0.CMD_READY_O); end
      n_checks++; if (if_main.CMD_READY_O !== 1'b1) begin n_fail++; $display("FAIL b2b_main_ready_c3 got=%0h exp=1", if_main.CMD_READY_O); end
      tick(); // edge 3: write accepted
      cmd_valid = 1'b0;
      n_checks++; if (if_t0.WRITE_VALID_O !== 1'b1) begin n_fail++; $display("FAIL b2b_write_valid got=%0h exp=1", if_t0.WRITE_VALID_O); end
      n_checks++; if (if_t0.WRITE_DATA_O !== 8'h22) begin n_fail++; $display("FAIL b2b_write_data got=%0h exp=22", if_t0.WRITE_DATA_O); end
      tick();
      n_checks++; if (if_t0.RSP_VALID_O !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_rsp_valid got=%0h exp=1", if_t0.RSP_VALID_O); end
      n_checks++; if (if_t0.RSP_ERROR_O !== 1'b0) begin n_fail++; $display("FAIL b2b_wr_rsp_error got=%0h exp=0", if_t0.RSP_ERROR_O); end
      n_checks++; if (if_t0.RSP_DATA_O !== 8'h00) begin n_fail++; $display("FAIL b2b_wr_rsp_data got=%0h exp=0", if_t0.RSP_DATA_O); end
      tick();
      // TIMEOUT=0: a long stall never aborts.
      read_valid = 1'b0;
      cmd_valid  = 1'b1;
      cmd_write  = 1'b0;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         n_checks++; if (if_t0.RSP_VALID_O !== 1'b0) begin n_fail++; $display("FAIL t0_no_timeout c%0d got=%0h exp=0", i, if_t0.RSP_VALID_O); end
         tick();
      end
      n_checks++; if (if_t0.READ_READY_O !== 1'b1) begin n_fail++; $display("FAIL t0_still_waiting got=%0h exp=1", if_t0.READ_READY_O); end
      read_valid = 1'b1;
      read_data  = 8'hC3;
      rsp_ready  = 1'b0;
      tick();
      read_valid = 1'b0;
      n_checks++; if (if_t0.RSP_VALID_O !== 1'b1) begin n_fail++; $display("FAIL t0_rsp_valid got=%0h exp=1", if_t0.RSP_VALID_O); end
      n_checks++; if (if_t0.RSP_ERROR_O !== 1'b0) begin n_fail++; $display("FAIL t0_rsp_error got=%0h exp=0", if_t0.RSP_ERROR_O); end
      n_checks++; if (if_t0.RSP_DATA_O !== 8'hC3) begin n_fail++; $display("FAIL t0_rsp_data got=%0h exp=c3", if_t0.RSP_DATA_O); end
      rsp_ready   = 1'b1;
      tick();
      rsp_ready   = 1'b0;
      write_ready = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      cmd_valid   = 1'b0;
      cmd_write   = 1'b0;
      cmd_data    = '0;
      rsp_ready   = 1'b0;
      read_valid  = 1'b0;
      read_data   = '0;
      write_ready = 1'b0;

      test_reset();
      test_read_immediate();
      test_write_delayed();
      test_timeout();
      test_backpressure();
      test_reset_mid_write();
      test_back_to_back();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
